// File: rtl/md4_search_ctrl.sv
// ---------------------------------------------------------------------------
// md4_search_ctrl
// Candidate-search controller around md4_pipe. Issues one candidate per
// clock from an inclusive (possibly wrapping) range, tracks each candidate
// through a p_latency-deep alignment shift register, compares the returned
// digest with the target, and reports the first match or range exhaustion.
//
// Ports:
//   clk            - clock, rising edge
//   rstN           - asynchronous active-low reset
//   start          - one-cycle search request (honoured in IDLE / DONE)
//   start_value    - first candidate, sampled with start
//   end_value      - last candidate (inclusive), sampled with start
//   target         - digest to match, sampled with start
//   pipe_inp_data  - candidate to md4_pipe (registered)
//   pipe_outp_data - digest from md4_pipe
//   busy           - high while searching or draining
//   done           - one-cycle pulse at end of search
//   found          - a match was seen in the current / last search
//   found_value    - first matching candidate
// ---------------------------------------------------------------------------
module md4_search_ctrl #(
   parameter int unsigned p_inp_data_len = 32,
   parameter int unsigned p_width        = 32,
   parameter int unsigned p_latency      = 48
) (
   input  logic                      clk,
   input  logic                      rstN,
   input  logic                      start,
   input  logic [p_inp_data_len-1:0] start_value,
   input  logic [p_inp_data_len-1:0] end_value,
   input  logic [p_width*4-1:0]      target,
   output logic [p_inp_data_len-1:0] pipe_inp_data,
   input  logic [p_width*4-1:0]      pipe_outp_data,
   output logic                      busy,
   output logic                      done,
   output logic                      found,
   output logic [p_inp_data_len-1:0] found_value
);

   localparam int unsigned CandW  = p_inp_data_len;
   localparam int unsigned DigW   = p_width * 4;
   localparam int unsigned DrainW = (p_latency > 1) ? $clog2(p_latency) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // One alignment entry: candidate plus a flag saying it was really issued.
   typedef struct packed {
      logic             vld;
      logic [CandW-1:0] val;
   } align_t;

   state_e              state_q, state_d;

   logic [CandW-1:0]    cnt_q;
   logic [CandW-1:0]    end_q;
   logic [DigW-1:0]     target_q;
   logic [DrainW-1:0]   drain_q;

   // pipe_q/pipe_vld_q is the issue stage; sr_q follows it so the tail
   // lines up with the digest exactly p_latency cycles after issue.
   logic [CandW-1:0]    pipe_q;
   logic                pipe_vld_q;
   align_t              sr_q [p_latency];

   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                found_q, found_d;
   logic [CandW-1:0]    found_value_q, found_value_d;

   logic                start_ok_c;
   logic                match_c;
   logic                last_c;
   logic                drain_last_c;
   logic                issue_c;

   align_t              tail_c;

   assign tail_c       = sr_q[p_latency-1];
   assign start_ok_c   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign match_c      = tail_c.vld && (pipe_outp_data == target_q);
   assign last_c       = (cnt_q == end_q);
   assign drain_last_c = (drain_q == DrainW'(p_latency - 1));

   // State register.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (start) state_d = ST_SEARCH;
         ST_SEARCH: if (match_c || last_c) state_d = ST_DRAIN;
         ST_DRAIN:  if (drain_last_c) state_d = ST_DONE;
         ST_DONE:   state_d = start ? ST_SEARCH : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output / control decode.
   always_comb begin
      busy_d        = (state_d == ST_SEARCH) || (state_d == ST_DRAIN);
      done_d        = (state_q == ST_DONE);
      found_d       = found_q;
      found_value_d = found_value_q;
      // A match stops issuing in the same cycle it is seen.
      issue_c       = (state_q == ST_SEARCH) && !match_c;
      if (start_ok_c) begin
         found_d       = 1'b0;
         found_value_d = '0;
      end else if (match_c && !found_q) begin
         found_d       = 1'b1;
         found_value_d = tail_c.val;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         found_q       <= 1'b0;
         found_value_q <= '0;
      end else begin
         busy_q        <= busy_d;
         done_q        <= done_d;
         found_q       <= found_d;
         found_value_q <= found_value_d;
      end
   end

   // Search parameters and candidate counter.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         cnt_q    <= '0;
         end_q    <= '0;
         target_q <= '0;
      end else if (start_ok_c) begin
         cnt_q    <= start_value;
         end_q    <= end_value;
         target_q <= target;
      end else if (issue_c) begin
         cnt_q    <= cnt_q + CandW'(1);
      end
   end

   // Issue stage; holds the last issued value while not issuing.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         pipe_q     <= '0;
         pipe_vld_q <= 1'b0;
      end else if (start_ok_c) begin
         pipe_vld_q <= 1'b0;
      end else begin
         pipe_vld_q <= issue_c;
         if (issue_c) pipe_q <= cnt_q;
      end
   end

   // Alignment shift register; a new search flushes any leftover entries.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int i = 0; i < int'(p_latency); i++) begin
            sr_q[i] <= '0;
         end
      end else if (start_ok_c) begin
         for (int i = 0; i < int'(p_latency); i++) begin
            sr_q[i].vld <= 1'b0;
         end
      end else begin
         sr_q[0] <= '{vld: pipe_vld_q, val: pipe_q};
         for (int i = 1; i < int'(p_latency); i++) begin
            sr_q[i] <= sr_q[i-1];
         end
      end
   end

   // Drain cycle counter.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         drain_q <= '0;
      end else if (state_q != ST_DRAIN) begin
         drain_q <= '0;
      end else begin
         drain_q <= drain_q + DrainW'(1);
      end
   end

   assign pipe_inp_data = pipe_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign found         = found_q;
   assign found_value   = found_value_q;

endmodule

// File: tb/tb_md4_search_ctrl.sv
// Bench for md4_search_ctrl using a stub pipe: outp = {4{inp}} delayed L.
module tb_md4_search_ctrl;

   localparam int unsigned L = 4;

   logic         clk = 1'b0;
   logic         rstN = 1'b0;
   logic         start = 1'b0;
   logic [31:0]  start_value = '0;
   logic [31:0]  end_value = '0;
   logic [127:0] target = '0;
   logic [31:0]  pipe_inp_data;
   logic [127:0] pipe_outp_data;
   logic         busy;
   logic         done;
   logic         found;
   logic [31:0]  found_value;

   int total = 0;
   int bad = 0;

   md4_search_ctrl #(
      .p_inp_data_len(32),
      .p_width(32),
      .p_latency(L)
   ) dut (
      .clk(clk),
      .rstN(rstN),
      .start(start),
      .start_value(start_value),
      .end_value(end_value),
      .target(target),
      .pipe_inp_data(pipe_inp_data),
      .pipe_outp_data(pipe_outp_data),
      .busy(busy),
      .done(done),
      .found(found),
      .found_value(found_value)
   );

   always #5 clk = ~clk;

   // Stub pipe: L register stages.
   logic [31:0] stub_q [L];
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int i = 0; i < int'(L); i++) stub_q[i] <= '0;
      end else begin
         stub_q[0] <= pipe_inp_data;
         for (int i = 1; i < int'(L); i++) stub_q[i] <= stub_q[i-1];
      end
   end
   assign pipe_outp_data = {4{stub_q[L-1]}};

   typedef struct {
      logic [31:0] sv;
      logic [31:0] ev;
      logic [31:0] tg;
      logic        e_found;
      logic [31:0] e_val;
      int          e_iss;    // candidates actually issued
      int          e_busy;   // cycles busy is high
      int          e_done;   // edges from start to done visible
      int          e_fedge;  // edges from start to found visible (0: none)
   } vec_t;

   typedef struct {
      logic        f;
      logic [31:0] val;
   } res_t;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_pipe"},  128'(pipe_inp_data), 128'(0));
      check({tag, "_busy"},  128'(busy),          128'(0));
      check({tag, "_done"},  128'(done),          128'(0));
      check({tag, "_found"}, 128'(found),         128'(0));
      check({tag, "_fval"},  128'(found_value),   128'(0));
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [31:0] iss_q [$];
      res_t        res_q [$];
      res_t        r;
      logic [31:0] c;
      int          busy_n = 0;
      int          done_n = 0;
      int          done_edge = 0;
      int          fedge = 0;

      @(negedge clk);
      start       = 1'b1;
      start_value = v.sv;
      end_value   = v.ev;
      target      = {4{v.tg}};
      c = v.sv;
      for (int i = 0; i < v.e_iss; i++) begin
         iss_q.push_back(c);
         c = c + 32'd1;
      end
      res_q.push_back('{f: v.e_found, val: v.e_val});

      // k counts edges after the start-sampling edge T (k = 0 is T itself).
      for (int k = 0; k <= v.e_done + 3; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) start = 1'b0;
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (done_edge == 0) done_edge = k;
         end
         if (found && fedge == 0) fedge = k;
         if (k == 1) check({tag, "_found_cleared"}, 128'(found), 128'(0));
         if (k >= 1 && iss_q.size() > 0) begin
            c = iss_q.pop_front();
            check({tag, "_issue"}, 128'(pipe_inp_data), 128'(c));
         end
         if (done && res_q.size() > 0) begin
            r = res_q.pop_front();
            check({tag, "_found"}, 128'(found), 128'(r.f));
            check({tag, "_found_value"}, 128'(found_value), 128'(r.val));
         end
      end
      check({tag, "_done_timeout"}, 128'(res_q.size()), 128'(0));
      check({tag, "_busy_cycles"}, 128'(busy_n), 128'(v.e_busy));
      check({tag, "_done_edge"}, 128'(done_edge), 128'(v.e_done));
      check({tag, "_done_pulses"}, 128'(done_n), 128'(1));
      check({tag, "_found_edge"}, 128'(fedge), 128'(v.e_fedge));
   endtask

   vec_t vecs [7];
   vec_t v7;
   int   seen;

   initial begin
      //          sv            ev            tg            f     val           iss busy done fedge
      vecs[0] = '{32'h10,       32'h1F,       32'h18,       1'b1, 32'h18,       13, 18, 19, 14};
      vecs[1] = '{32'h20,       32'h2F,       32'h55,       1'b0, 32'h0,        16, 20, 21, 0};
      vecs[2] = '{32'hFFFFFFFE, 32'h1,        32'h0,        1'b1, 32'h0,        4,  8,  9,  8};
      vecs[3] = '{32'h7,        32'h7,        32'h7,        1'b1, 32'h7,        1,  5,  6,  6};
      vecs[4] = '{32'h100,      32'h100,      32'h5,        1'b0, 32'h0,        1,  5,  6,  0};
      vecs[5] = '{32'h30,       32'h3F,       32'h3F,       1'b1, 32'h3F,       16, 20, 21, 21};
      vecs[6] = '{32'h40,       32'h4F,       32'h4A,       1'b1, 32'h4A,       15, 20, 21, 16};

      rstN = 1'b0;
      #100;
      check_idle_outputs("reset");
      @(negedge clk);
      rstN = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
         repeat (2) @(negedge clk);
      end

      // Start mid-SEARCH must be ignored; reset mid-DRAIN aborts silently.
      @(negedge clk);
      start       = 1'b1;
      start_value = 32'h60;
      end_value   = 32'h6F;
      target      = {4{32'h99}};
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      start       = 1'b1;
      start_value = 32'h200;
      end_value   = 32'h201;
      target      = {4{32'h205}};
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1;
      check("ign_start_issue", 128'(pipe_inp_data), 128'(32'h64));
      check("ign_start_busy", 128'(busy), 128'(1));
      repeat (13) @(posedge clk);
      #1;
      check("drain_busy", 128'(busy), 128'(1));
      check("drain_hold", 128'(pipe_inp_data), 128'(32'h6F));
      rstN = 1'b0;
      #1;
      check_idle_outputs("midreset");
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      seen = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen++;
      end
      check("no_done_after_reset", 128'(seen), 128'(0));

      v7 = '{32'h7, 32'h7, 32'h7, 1'b1, 32'h7, 1, 5, 6, 6};
      run_vec(v7, "after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
